// File: rtl/mem_wb_skid_pipe.sv
// MEM/WB pipeline register with a two-entry skid buffer, flush and writeback mux.
// in_ready comes straight from a flop, so out_ready never reaches it combinationally.
module mem_wb_skid_pipe #(
    parameter int DATA_W            = 32,
    parameter int REG_W             = 5,
    parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_W-1:0]  write_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en
);

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  wreg;
    } entry_t;

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;

    entry_t w_in;
    logic   w_accept;
    logic   w_drain;
    logic   w_zero_dest;

    assign w_in = '{regwrite: RegWrite, memtoreg: MemtoReg, rdata: read_data_in,
                    alu: alu_result_in, wreg: write_reg_in};

    assign w_accept = in_valid & ~r_skid_valid;
    assign w_drain  = ~r_main_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // Data fields are left alone; only the valid bits are killed.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                if (w_accept) begin
                    r_skid <= w_in;
                end
                r_skid_valid <= w_accept;
            end else begin
                if (w_accept) begin
                    r_main <= w_in;
                end
                r_main_valid <= w_accept;
            end
        end else if (w_accept) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready       = ~r_skid_valid;
    assign out_valid      = r_main_valid;
    assign RegWrite_out   = r_main.regwrite;
    assign MemtoReg_out   = r_main.memtoreg;
    assign read_data      = r_main.rdata;
    assign mem_alu_result = r_main.alu;
    assign mem_write_reg  = r_main.wreg;

    assign wb_data     = r_main.memtoreg ? r_main.rdata : r_main.alu;
    assign w_zero_dest = ZERO_REG_SUPPRESS && (r_main.wreg == '0);
    assign wb_en       = r_main_valid & out_ready & r_main.regwrite & ~w_zero_dest;

endmodule

// File: tb/tb_mem_wb_skid_pipe.sv
// Bench for mem_wb_skid_pipe: directed cases plus a random stream, all output
// handshakes checked against an expected queue in arrival order.
module tb_mem_wb_skid_pipe;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int EW = 2 + 2 * DW + RW;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          reg_write;
  logic          memto_reg;
  logic [DW-1:0] read_data_in;
  logic [DW-1:0] alu_result_in;
  logic [RW-1:0] write_reg_in;
  logic          out_valid;
  logic          out_ready;
  logic          reg_write_out;
  logic          memto_reg_out;
  logic [DW-1:0] read_data;
  logic [DW-1:0] mem_alu_result;
  logic [RW-1:0] mem_write_reg;
  logic [DW-1:0] wb_data;
  logic          wb_en;

  // second instance with zero-register suppression disabled
  logic          ns_in_ready;
  logic          ns_out_valid;
  logic          ns_reg_write_out;
  logic          ns_memto_reg_out;
  logic [DW-1:0] ns_read_data;
  logic [DW-1:0] ns_mem_alu_result;
  logic [RW-1:0] ns_mem_write_reg;
  logic [DW-1:0] ns_wb_data;
  logic          ns_wb_en;

  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;
  int            n_acc;

  mem_wb_skid_pipe #(.DATA_W(DW), .REG_W(RW), .ZERO_REG_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite(reg_write), .MemtoReg(memto_reg), .read_data_in(read_data_in),
    .alu_result_in(alu_result_in), .write_reg_in(write_reg_in),
    .out_valid(out_valid), .out_ready(out_ready), .RegWrite_out(reg_write_out),
    .MemtoReg_out(memto_reg_out), .read_data(read_data), .mem_alu_result(mem_alu_result),
    .mem_write_reg(mem_write_reg), .wb_data(wb_data), .wb_en(wb_en)
  );

  mem_wb_skid_pipe #(.DATA_W(DW), .REG_W(RW), .ZERO_REG_SUPPRESS(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ns_in_ready),
    .RegWrite(reg_write), .MemtoReg(memto_reg), .read_data_in(read_data_in),
    .alu_result_in(alu_result_in), .write_reg_in(write_reg_in),
    .out_valid(ns_out_valid), .out_ready(out_ready), .RegWrite_out(ns_reg_write_out),
    .MemtoReg_out(ns_memto_reg_out), .read_data(ns_read_data),
    .mem_alu_result(ns_mem_alu_result), .mem_write_reg(ns_mem_write_reg),
    .wb_data(ns_wb_data), .wb_en(ns_wb_en)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [EW-1:0] pack(input logic rw, input logic m2r,
                                         input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                                         input logic [RW-1:0] wr);
    return {rw, m2r, rd, alu, wr};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: called just after a rising edge; applies inputs for one cycle and
  // records what the DUT accepts (or drops on flush) into the expected queue
  task automatic cycle(input logic v, input logic rw, input logic m2r,
                       input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                       input logic [RW-1:0] wr, input logic fl, input logic ordy);
    in_valid      = v;
    reg_write     = rw;
    memto_reg     = m2r;
    read_data_in  = rd;
    alu_result_in = alu;
    write_reg_in  = wr;
    flush         = fl;
    out_ready     = ordy;
    @(negedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else if (v && in_ready) begin
      exp_q.push_back(pack(rw, m2r, rd, alu, wr));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, ordy);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // monitor / scoreboard
  logic [EW-1:0] m_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got alu=%h reg=%0d with nothing expected",
                   mem_alu_result, mem_write_reg);
        end else begin
          m_e = exp_q.pop_front();
          chk("out_fields", {reg_write_out, memto_reg_out, read_data, mem_alu_result,
                             mem_write_reg}, m_e);
          chk("out_wb_data", EW'(wb_data),
              EW'(m_e[EW-2] ? m_e[EW-3 -: DW] : m_e[EW-3-DW -: DW]));
          chk("out_wb_en", EW'(wb_en), EW'(m_e[EW-1] && (m_e[RW-1:0] != '0)));
        end
      end else begin
        chk("idle_wb_en", EW'(wb_en), EW'(0));
      end
    end
  end

  int base;
  initial begin
    checks = 0;
    errors = 0;
    n_acc  = 0;
    reg_write = 1'b0; memto_reg = 1'b0;
    read_data_in = '0; alu_result_in = '0; write_reg_in = '0;

    // reset state
    do_reset();
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", EW'(out_valid), EW'(0));
    chk("rst_in_ready", EW'(in_ready), EW'(1));
    chk("rst_fields", {reg_write_out, memto_reg_out, read_data, mem_alu_result,
                       mem_write_reg}, EW'(0));
    chk("rst_wb_data", EW'(wb_data), EW'(0));
    chk("rst_wb_en", EW'(wb_en), EW'(0));

    // pass-through, memory source, register 31
    cycle(1'b1, 1'b1, 1'b1, DW'(111), DW'('h77), RW'(31), 1'b0, 1'b1);
    chk("pt_out_valid", EW'(out_valid), EW'(1));
    chk("pt_wb_data", EW'(wb_data), EW'(111));
    chk("pt_wb_en", EW'(wb_en), EW'(1));
    chk("pt_write_reg", EW'(mem_write_reg), EW'(31));
    idle(1'b1);

    // skid: A then B while stalled, then a third offer that must be ignored
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'(5), RW'(7), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'(6), RW'(8), 1'b0, 1'b0);
    chk("skid_in_ready", EW'(in_ready), EW'(0));
    chk("skid_main_a", EW'(mem_alu_result), EW'(5));
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'(7), RW'(9), 1'b0, 1'b0);
    chk("full_in_ready", EW'(in_ready), EW'(0));
    chk("full_main_a", EW'(mem_alu_result), EW'(5));
    idle(1'b1);
    chk("skid_main_b", EW'(mem_alu_result), EW'(6));
    chk("skid_b_valid", EW'(out_valid), EW'(1));
    chk("skid_ready_back", EW'(in_ready), EW'(1));
    idle(1'b1);
    chk("skid_drained", EW'(out_valid), EW'(0));

    // zero register destination
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'(9), RW'(0), 1'b0, 1'b1);
    chk("zr_out_valid", EW'(out_valid), EW'(1));
    chk("zr_wb_data", EW'(wb_data), EW'(9));
    chk("zr_wb_en_sup", EW'(wb_en), EW'(0));
    chk("zr_wb_en_nosup", EW'(ns_wb_en), EW'(1));
    idle(1'b1);

    // flush with both entries full and an offered input
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'('h21), RW'(3), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'('h22), RW'(3), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'('h23), RW'(3), 1'b1, 1'b0);
    chk("fl_full_valid", EW'(out_valid), EW'(0));
    chk("fl_full_ready", EW'(in_ready), EW'(1));
    chk("fl_full_data_held", EW'(mem_alu_result), EW'('h21));
    // flush discards an input accepted in the same cycle
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'('h24), RW'(3), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'('h25), RW'(3), 1'b1, 1'b0);
    chk("fl_acc_valid", EW'(out_valid), EW'(0));
    chk("fl_acc_ready", EW'(in_ready), EW'(1));
    chk("fl_acc_data_held", EW'(mem_alu_result), EW'('h24));
    // flush together with out_ready: the main entry still writes back
    cycle(1'b1, 1'b1, 1'b0, DW'(0), DW'('h26), RW'(4), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // reset while stalled with both entries full
    cycle(1'b1, 1'b1, 1'b1, DW'('h31), DW'('h41), RW'(5), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, DW'('h32), DW'('h42), RW'(6), 1'b0, 1'b0);
    do_reset();
    out_ready = 1'b1;
    #1;
    chk("mrst_out_valid", EW'(out_valid), EW'(0));
    chk("mrst_in_ready", EW'(in_ready), EW'(1));
    chk("mrst_wb_en", EW'(wb_en), EW'(0));
    chk("mrst_fields", {reg_write_out, memto_reg_out, read_data, mem_alu_result,
                        mem_write_reg}, EW'(0));
    idle(1'b1);

    // random stream of 200 accepted items
    base = n_acc;
    for (int it = 0; it < 4000 && (n_acc - base) < 200; it++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            DW'($urandom), DW'($urandom), RW'($urandom_range(0, 31)), 1'b0,
            $urandom_range(0, 2) != 0);
    end
    chk("stream_count", EW'(n_acc - base), EW'(200));
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("stream_queue_empty", EW'(exp_q.size()), EW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
